imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction loader and instruction-SRAM port arbiter upstream of the processor datapath. It receives a byte stream over a valid/ready handshake and packs it into 32-bit little-endian instruction words. It writes those words into the instruction SRAM from address 0 and holds the CPU until the programmed word count is loaded. After loading, it hands the SRAM read port to the datapath's `imem_en`/`imem_addr`/`imem_data` interface.

## Interface

Parameters:
- `ADDR_W`, default `INST_ADDR_WIDTH` (10): instruction SRAM word-address width.
- `DATA_W`, default `INST_DATA_WIDTH` (32): instruction width. Fixed at 32; other values are unsupported.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous active-high reset.
- `boot_start`, in, 1: single-cycle load request.
- `boot_len`, in, `ADDR_W+1`: number of words to load; latched on an accepted `boot_start`.
- `rx_data`, in, 8: stream byte.
- `rx_valid`, in, 1: stream byte valid.
- `rx_ready`, out, 1: loader accepts a byte.
- `cpu_imem_en`, in, 1: datapath fetch enable.
- `cpu_imem_addr`, in, `ADDR_W`: datapath fetch word address.
- `cpu_imem_data`, out, 32: instruction returned to the datapath.
- `sram_en`, out, 1: SRAM enable.
- `sram_we`, out, 1: SRAM write enable.
- `sram_addr`, out, `ADDR_W`: SRAM word address.
- `sram_wdata`, out, 32: SRAM write data.
- `sram_rdata`, in, 32: SRAM read data, synchronous, 1-cycle latency.
- `cpu_hold`, out, 1: high means the CPU must not advance.
- `busy`, out, 1: high while loading.
- `done`, out, 1: load complete.
- `err`, out, 1: `boot_len` was rejected.
- `chk_sum`, out, 8: mod-256 sum of the bytes accepted since the last accepted `boot_start`.

## Operation

- FSM states: `IDLE`, `RECV`, `WRITE`, `DONE`.
- `IDLE`:
  - `cpu_hold`=1 and `rx_ready`=0.
  - `boot_start` with 1 ≤ `boot_len` ≤ 2^`ADDR_W` → `RECV`.
  - On that transition: clear `word_cnt`, `byte_cnt`, `chk_sum` and `err`; latch `boot_len`.
  - `boot_start` with an illegal length → set `err`=1 and stay in `IDLE`.
- `RECV`:
  - `rx_ready`=1.
  - Each transfer (`rx_valid`&`rx_ready`) places the byte at lane `byte_cnt` (byte 0 → bits [7:0]).
  - Each transfer adds the byte to `chk_sum` and increments the 2-bit `byte_cnt`.
  - A transfer with `byte_cnt`=3 → `WRITE`.
- `WRITE`:
  - `rx_ready`=0; drive `sram_en`=1, `sram_we`=1, `sram_addr`=`word_cnt`, `sram_wdata`=assembled word.
  - Increment `word_cnt`.
  - If `word_cnt`+1 == latched length → `DONE`, else → `RECV`.
- `DONE`:
  - `cpu_hold`=0 and `done`=1.
  - `sram_en`=`cpu_imem_en`, `sram_addr`=`cpu_imem_addr`, `sram_we`=0 (combinational passthrough).
  - `cpu_imem_data`=`sram_rdata`; in all other states `cpu_imem_data`=0.
  - `boot_start` with a legal length → `RECV`, with `cpu_hold` rising the next cycle; an illegal length sets `err` and stays in `DONE`.
- `boot_start` in `RECV` or `WRITE` is ignored.
- `busy`=1 in `RECV` and `WRITE` only.
- The SRAM is idle (`sram_en`=0) in `IDLE` and `RECV`, and `sram_addr`/`sram_wdata` are driven 0 there.
- `word_cnt` is `ADDR_W+1` bits wide, so a load of exactly 2^`ADDR_W` words terminates without wrap.
- `err` is sticky until the next accepted `boot_start`.

## Timing

- Reset values, applied immediately on `rst` assertion:
  - state `IDLE`; `rx_ready`=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0;
  - `cpu_hold`=1, `busy`=0, `done`=0, `err`=0, `chk_sum`=0, `cpu_imem_data`=0.
- Reset mid-load discards any partial word; SRAM contents already written are left untouched.
- `boot_start` sampled at edge t → `rx_ready`=1 from t+1.
- The 4th byte accepted at edge t → `sram_we`=1 during cycle t+1 → `rx_ready` is back at t+2, or `DONE` is entered at t+2.
- With `rx_valid` held high, N words take 1+5N cycles from `boot_start` to `done`.
- `cpu_hold` falls, and `done` rises, on the same edge that enters `DONE`. Both are registered state decodes.
- CPU fetch in `DONE`: address presented in cycle c → `cpu_imem_data` valid in c+1, per SRAM latency.

## Structure

- `cpu_pkg` holds `loader_state_t` (enum of the four states) and reuses the existing `INST_ADDR_WIDTH`/`INST_DATA_WIDTH`.
- One sub-module, `word_assembler`: byte-lane shift register plus `byte_cnt`, with a `word_valid` pulse on the 4th byte. It is reset and cleared by the loader.
- FSM, counters, checksum and port mux live in `imem_loader`.

## Test plan

- Reset: assert `rst` mid-cycle → all outputs reach their reset values asynchronously, with `cpu_hold`=1.
- Load `boot_len`=2 with bytes 78 56 34 12 EF BE AD DE sent back-to-back:
  - SRAM[0]=0x12345678 and SRAM[1]=0xDEADBEEF;
  - `done` 11 cycles after `boot_start`;
  - `chk_sum`=0x4C.
- Same load with random `rx_valid` gaps → identical SRAM contents and `chk_sum`; no byte is accepted while `rx_ready`=0.
- `boot_len`=0, then `boot_len`=1025 with `ADDR_W`=10 → `err`=1, state stays `IDLE`, no SRAM write.
- Assert `rst` after 6 bytes of a 2-word load → no further writes; a subsequent 1-word load writes address 0 correctly.
- In `DONE`, `cpu_imem_en`=1 and `cpu_imem_addr`=1 → `sram_addr`=1 the same cycle and `cpu_imem_data`=0xDEADBEEF the next cycle. A `boot_start` issued afterwards raises `cpu_hold` and `busy`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared processor-side definitions: instruction memory geometry and loader states.
package cpu_pkg;

  localparam int unsigned INST_ADDR_WIDTH = 10;
  localparam int unsigned INST_DATA_WIDTH = 32;
  localparam int unsigned BYTE_W          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into little-endian words; byte 0 ends up in bits [7:0].
module word_assembler
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = INST_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;

  // Next state: shift new bytes in from the top so the first byte lands in lane 0.
  always_comb begin
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    if (clr_i) begin
      word_d     = '0;
      byte_cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      word_d     = {byte_i, word_q[DATA_W-1:BYTE_W]};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  // Lane shift register and byte counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      byte_cnt_q <= 2'd0;
    end else begin
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction SRAM from a byte stream, then hands the port to the CPU.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_WIDTH,
  parameter int unsigned DATA_W = INST_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_start,
  input  logic [ADDR_W:0]   boot_len,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              cpu_imem_en,
  input  logic [ADDR_W-1:0] cpu_imem_addr,
  output logic [DATA_W-1:0] cpu_imem_data,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BYTE_W-1:0] chk_sum
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     state_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  len_q;
  logic [BYTE_W-1:0] chk_q;
  logic              err_q;

  logic              len_ok;
  logic              start_ok;
  logic              xfer;
  logic              word_valid;
  logic [DATA_W-1:0] asm_word;

  assign len_ok   = (boot_len != '0) && (boot_len <= MAX_LEN);
  assign start_ok = boot_start && len_ok && ((state_q == IDLE) || (state_q == DONE));
  assign xfer     = rx_valid && rx_ready;

  word_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_ok),
    .byte_valid_i (xfer),
    .byte_i       (rx_data),
    .word_o       (asm_word),
    .word_valid_o (word_valid)
  );

  // Loader FSM with word counter, latched length, checksum and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      chk_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_q    <= RECV;
            word_cnt_q <= '0;
            len_q      <= boot_len;
            chk_q      <= '0;
            err_q      <= 1'b0;
          end else if (boot_start) begin
            err_q <= 1'b1;
          end
        end
        RECV: begin
          if (xfer) begin
            chk_q <= chk_q + rx_data;
            if (word_valid) begin
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_q + CNT_W'(1);
          if ((word_cnt_q + CNT_W'(1)) == len_q) begin
            state_q <= DONE;
          end else begin
            state_q <= RECV;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // SRAM port mux: loader writes in WRITE, CPU passthrough in DONE, idle otherwise.
  always_comb begin
    sram_en       = 1'b0;
    sram_we       = 1'b0;
    sram_addr     = '0;
    sram_wdata    = '0;
    cpu_imem_data = '0;
    case (state_q)
      WRITE: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = word_cnt_q[ADDR_W-1:0];
        sram_wdata = asm_word;
      end
      DONE: begin
        sram_en       = cpu_imem_en;
        sram_addr     = cpu_imem_addr;
        cpu_imem_data = sram_rdata;
      end
      default: ;
    endcase
  end

  assign rx_ready = (state_q == RECV);
  assign busy     = (state_q == RECV) || (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign cpu_hold = (state_q != DONE);
  assign err      = err_q;
  assign chk_sum  = chk_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with an SRAM model and a write scoreboard.
module tb_imem_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_start;
  logic [AW:0]   boot_len;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          cpu_imem_en;
  logic [AW-1:0] cpu_imem_addr;
  logic [31:0]   cpu_imem_data;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    chk_sum;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] tx_bytes[$];
  logic [7:0] chk_model;
  logic [31:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  imem_loader #(
    .ADDR_W (AW),
    .DATA_W (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .boot_start    (boot_start),
    .boot_len      (boot_len),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .cpu_imem_en   (cpu_imem_en),
    .cpu_imem_addr (cpu_imem_addr),
    .cpu_imem_data (cpu_imem_data),
    .sram_en       (sram_en),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .chk_sum       (chk_sum)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      sram_rdata <= mem[sram_addr];
    end
  end

  // Scoreboard: every SRAM write must match the next expected write.
  always @(negedge clk) begin
    if (!rst && sram_en && sram_we) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sram_unexpected_write observed addr=%0h data=%0h expected=no write", sram_addr, sram_wdata);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        total++;
        assert ({sram_addr, sram_wdata} === {mon_e.addr, mon_e.data}) else begin
          bad++;
          $error("FAIL sram_write observed addr=%0h data=%0h expected addr=%0h data=%0h",
                 sram_addr, sram_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rx_ready"}, 64'(rx_ready), 64'(0));
    check({pfx, "_sram_en"}, 64'(sram_en), 64'(0));
    check({pfx, "_sram_we"}, 64'(sram_we), 64'(0));
    check({pfx, "_sram_addr"}, 64'(sram_addr), 64'(0));
    check({pfx, "_sram_wdata"}, 64'(sram_wdata), 64'(0));
    check({pfx, "_cpu_hold"}, 64'(cpu_hold), 64'(1));
    check({pfx, "_busy"}, 64'(busy), 64'(0));
    check({pfx, "_done"}, 64'(done), 64'(0));
    check({pfx, "_err"}, 64'(err), 64'(0));
    check({pfx, "_chk_sum"}, 64'(chk_sum), 64'(0));
    check({pfx, "_cpu_imem_data"}, 64'(cpu_imem_data), 64'(0));
  endtask

  // Queue the four bytes of a word and its expected SRAM write.
  task automatic add_word(input logic [AW-1:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) tx_bytes.push_back(w[8*k +: 8]);
    exp_q.push_back('{addr: a, data: w});
  endtask

  // Called #1 after an edge; returns #1 after the edge that samples boot_start.
  task automatic drive_boot(input logic [AW:0] len);
    boot_len   = len;
    boot_start = 1'b1;
    @(posedge clk); #1;
    boot_start = 1'b0;
    if (len != 0 && len <= 1024) chk_model = 8'h00;
  endtask

  // Feeds tx_bytes with optional valid gaps; edges counts from the boot_start edge.
  task automatic stream(input int nbytes, input int gap_pct, input bit wait_done,
                        input int max_cyc, output int edges);
    int idx;
    bit xfer;
    bit finished;
    idx = 0;
    edges = 1;
    finished = 1'b0;
    for (int c = 0; c < max_cyc && !finished; c++) begin
      if (idx < nbytes) begin
        rx_valid = (int'($urandom_range(99)) >= gap_pct);
        rx_data  = tx_bytes[idx];
      end else begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
      end
      xfer = rx_valid && rx_ready;
      @(posedge clk); #1;
      edges++;
      if (xfer) begin
        chk_model += tx_bytes[idx];
        idx++;
      end
      finished = wait_done ? (done === 1'b1) : (idx == nbytes);
    end
    rx_valid = 1'b0;
    check("stream_finished", 64'(finished), 64'(1));
  endtask

  initial begin
    int edges;
    logic [31:0] last_w;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1;
    boot_start = 1'b0;
    boot_len = '0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    cpu_imem_en = 1'b0;
    cpu_imem_addr = '0;
    chk_model = 8'h00;
    #1;
    check_reset_vals("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Two-word load, back-to-back bytes.
    tx_bytes.delete();
    add_word(10'd0, 32'h12345678);
    add_word(10'd1, 32'hDEADBEEF);
    drive_boot(11'd2);
    check("boot_rx_ready", 64'(rx_ready), 64'(1));
    check("boot_busy", 64'(busy), 64'(1));
    stream(8, 0, 1'b1, 100, edges);
    check("load2_latency", 64'(edges), 64'(11));
    check("load2_done", 64'(done), 64'(1));
    check("load2_hold", 64'(cpu_hold), 64'(0));
    check("load2_busy", 64'(busy), 64'(0));
    check("load2_chk", 64'(chk_sum), 64'h4C);
    check("load2_chk_model", 64'(chk_sum), 64'(chk_model));
    check("load2_sb_empty", 64'(exp_q.size()), 64'(0));

    // CPU fetch through the passthrough port.
    cpu_imem_en = 1'b1;
    cpu_imem_addr = 10'd1;
    #1;
    check("fetch_sram_addr", 64'(sram_addr), 64'(1));
    check("fetch_sram_en", 64'(sram_en), 64'(1));
    check("fetch_sram_we", 64'(sram_we), 64'(0));
    @(posedge clk); #1;
    check("fetch1_data", 64'(cpu_imem_data), 64'hDEADBEEF);
    cpu_imem_addr = 10'd0;
    @(posedge clk); #1;
    check("fetch0_data", 64'(cpu_imem_data), 64'h12345678);
    cpu_imem_en = 1'b0;

    // Reload from DONE.
    tx_bytes.delete();
    add_word(10'd0, 32'hCAFEF00D);
    drive_boot(11'd1);
    check("reboot_hold", 64'(cpu_hold), 64'(1));
    check("reboot_busy", 64'(busy), 64'(1));
    check("reboot_done", 64'(done), 64'(0));
    stream(4, 0, 1'b1, 100, edges);
    check("load1_latency", 64'(edges), 64'(6));
    check("load1_chk", 64'(chk_sum), 64'(chk_model));

    // Asynchronous reset mid-cycle while the CPU owns the port.
    cpu_imem_en = 1'b1;
    cpu_imem_addr = 10'd0;
    @(posedge clk); #1;
    check("fetch_reboot_data", 64'(cpu_imem_data), 64'hCAFEF00D);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("async");
    cpu_imem_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Illegal lengths from IDLE.
    drive_boot(11'd0);
    check("len0_err", 64'(err), 64'(1));
    check("len0_busy", 64'(busy), 64'(0));
    check("len0_ready", 64'(rx_ready), 64'(0));
    drive_boot(11'd1025);
    check("len1025_err", 64'(err), 64'(1));
    check("len1025_busy", 64'(busy), 64'(0));
    check("len1025_hold", 64'(cpu_hold), 64'(1));
    repeat (3) @(posedge clk);
    #1;

    // Reset after six bytes of a two-word load.
    tx_bytes.delete();
    add_word(10'd0, 32'h04030201);
    tx_bytes.push_back(8'h05);
    tx_bytes.push_back(8'h06);
    drive_boot(11'd2);
    check("legal_clears_err", 64'(err), 64'(0));
    stream(6, 0, 1'b0, 100, edges);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check("partial_sb_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("partial_idle", 64'(busy), 64'(0));
    tx_bytes.delete();
    add_word(10'd0, 32'h11223344);
    drive_boot(11'd1);
    stream(4, 0, 1'b1, 100, edges);
    check("after_rst_latency", 64'(edges), 64'(6));
    check("after_rst_chk", 64'(chk_sum), 64'hAA);
    check("after_rst_sb_empty", 64'(exp_q.size()), 64'(0));
    cpu_imem_en = 1'b1;
    cpu_imem_addr = 10'd0;
    @(posedge clk); #1;
    check("after_rst_fetch", 64'(cpu_imem_data), 64'h11223344);
    cpu_imem_en = 1'b0;

    // Illegal length from DONE keeps DONE.
    drive_boot(11'd2000);
    check("done_bad_err", 64'(err), 64'(1));
    check("done_bad_done", 64'(done), 64'(1));
    check("done_bad_hold", 64'(cpu_hold), 64'(0));

    // Same two-word load with random valid gaps.
    tx_bytes.delete();
    add_word(10'd0, 32'h12345678);
    add_word(10'd1, 32'hDEADBEEF);
    drive_boot(11'd2);
    check("gap_err_clr", 64'(err), 64'(0));
    stream(8, 40, 1'b1, 500, edges);
    check("gap_chk", 64'(chk_sum), 64'h4C);
    check("gap_done", 64'(done), 64'(1));
    check("gap_sb_empty", 64'(exp_q.size()), 64'(0));

    // Full-depth load: 2^AW words must terminate without wrapping.
    tx_bytes.delete();
    last_w = 32'h0;
    for (int w = 0; w < 1024; w++) begin
      last_w = $urandom();
      add_word(AW'(w), last_w);
    end
    drive_boot(11'd1024);
    stream(4096, 0, 1'b1, 6000, edges);
    check("full_latency", 64'(edges), 64'(5121));
    check("full_done", 64'(done), 64'(1));
    check("full_chk", 64'(chk_sum), 64'(chk_model));
    check("full_sb_empty", 64'(exp_q.size()), 64'(0));
    cpu_imem_en = 1'b1;
    cpu_imem_addr = 10'd1023;
    @(posedge clk); #1;
    check("full_fetch_last", 64'(cpu_imem_data), 64'(last_w));
    cpu_imem_en = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
